// File: rtl/qci_handshake_mc_pkg.sv
// Shared types and constants for the multi-channel QCI handshake block.
// FSM state encoding, drop counter width and a saturating increment helper.
package qci_pkg;

  typedef enum logic [1:0] {
    QCI_IDLE     = 2'd0,
    QCI_WAIT_EPR = 2'd1,
    QCI_APPLY    = 2'd2
  } qci_state_t;

  localparam int DROP_W = 16;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/qci_handshake_mc_if.sv
// Classical-in / correction-out bus of the QCI handshake block.
// master = instaweb RX side plus qhttp acceptor, slave = qci_handshake_mc.
interface qci_handshake_mc_if #(
  parameter int NCH    = 4,
  parameter int DATA_W = 8,
  parameter int CORR_W = 4
);
  localparam int CH_W = $clog2(NCH);

  // Handshake rule for both directions: a beat transfers on a rising edge where
  // valid && ready; a raised q_valid keeps q_corr/q_ch stable until it transfers
  // or is retired by the EPR-wait timeout. c_ready is a combinational !full[c_ch].
  logic [DATA_W-1:0] c_data;
  logic [CH_W-1:0]   c_ch;
  logic              c_valid;
  logic              c_ready;
  logic [CORR_W-1:0] q_corr;
  logic [CH_W-1:0]   q_ch;
  logic              q_valid;
  logic              q_ready;

  modport master (
    output c_data, c_ch, c_valid, q_ready,
    input  c_ready, q_corr, q_ch, q_valid
  );

  modport slave (
    input  c_data, c_ch, c_valid, q_ready,
    output c_ready, q_corr, q_ch, q_valid
  );

endinterface

// File: rtl/qci_handshake_mc_chan_fifo.sv
// Per-channel synchronous FIFO; extra pointer MSB separates full from empty.
// Reset clears only the pointers, which discards all buffered entries at once.
module qci_chan_fifo #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head,
  output logic [PTR_W:0]    count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/qci_handshake_mc.sv
// Multi-channel QCI handshake: per-channel FIFOs, round-robin grant onto one
// correction port, EPR-wait timeout with saturating drop accounting.
module qci_handshake_mc
  import qci_pkg::*;
#(
  parameter int  NCH     = 4,
  parameter int  DATA_W  = 8,
  parameter int  CORR_W  = 4,
  parameter int  DEPTH   = 16,
  parameter int  TIMEOUT = 1024,
  localparam int CH_W    = $clog2(NCH),
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int TMR_W   = $clog2(TIMEOUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  qci_handshake_mc_if.slave        bus,
  output logic [NCH-1:0]           sync_pulse,
  output logic [NCH-1:0]           timeout_err,
  output logic [NCH*(PTR_W+1)-1:0] occupancy,
  output logic [DROP_W-1:0]        drop_count,
  output qci_state_t               state_dbg
);

  logic [NCH-1:0]    full, empty, push, pop;
  logic [DATA_W-1:0] head [NCH];
  logic [NCH-1:0]    unused_head_par;
  logic              pop_en;

  qci_state_t        state_q, state_d;
  logic              q_valid_q, q_valid_d;
  logic [CORR_W-1:0] q_corr_q, q_corr_d;
  logic [CH_W-1:0]   q_ch_q, q_ch_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [NCH-1:0]    sync_q, sync_d;
  logic [NCH-1:0]    tout_q, tout_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   cand;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign push[i] = bus.c_valid && !full[i] && (bus.c_ch == CH_W'(i));
    assign pop[i]  = pop_en && (q_ch_q == CH_W'(i));
    // Only the low CORR_W payload bits feed the correction port.
    assign unused_head_par[i] = ^head[i];

    qci_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (bus.c_data),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i]),
      .count (occupancy[i*(PTR_W+1) +: (PTR_W+1)])
    );
  end

  assign bus.c_ready = !full[bus.c_ch];

  // Scan from the farthest candidate back to rr_q so the nearest non-empty
  // channel at or after the round-robin pointer is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = rr_q;
    cand        = rr_q;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = rr_q + CH_W'(k);
      if (!empty[cand]) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    q_valid_d = q_valid_q;
    q_corr_d  = q_corr_q;
    q_ch_d    = q_ch_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    drop_d    = drop_q;
    sync_d    = '0;
    tout_d    = '0;
    pop_en    = 1'b0;
    unique case (state_q)
      QCI_IDLE: begin
        if (grant_valid) begin
          q_ch_d    = grant_ch;
          q_corr_d  = head[grant_ch][CORR_W-1:0];
          q_valid_d = 1'b1;
          timer_d   = '0;
          state_d   = QCI_WAIT_EPR;
        end
      end
      QCI_WAIT_EPR: begin
        // An accept on the expiry cycle still counts as an accept.
        if (bus.q_ready) begin
          pop_en         = 1'b1;
          sync_d[q_ch_q] = 1'b1;
          q_valid_d      = 1'b0;
          state_d        = QCI_APPLY;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          pop_en         = 1'b1;
          tout_d[q_ch_q] = 1'b1;
          drop_d         = sat_inc(drop_q);
          q_valid_d      = 1'b0;
          state_d        = QCI_APPLY;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      QCI_APPLY: begin
        rr_d    = q_ch_q + CH_W'(1);
        state_d = QCI_IDLE;
      end
      default: state_d = QCI_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= QCI_IDLE;
      q_valid_q <= 1'b0;
      q_corr_q  <= '0;
      q_ch_q    <= '0;
      rr_q      <= '0;
      timer_q   <= '0;
      sync_q    <= '0;
      tout_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      q_valid_q <= q_valid_d;
      q_corr_q  <= q_corr_d;
      q_ch_q    <= q_ch_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      sync_q    <= sync_d;
      tout_q    <= tout_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.q_valid = q_valid_q;
  assign bus.q_corr  = q_corr_q;
  assign bus.q_ch    = q_ch_q;
  assign sync_pulse  = sync_q;
  assign timeout_err = tout_q;
  assign drop_count  = drop_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_qci_handshake_mc.sv
// Bench for qci_handshake_mc: vector table, directed corner sequences and a
// randomized run against a queue-based transaction model.
module tb_qci_handshake_mc;
  import qci_pkg::*;

  localparam int NCH     = 4;
  localparam int DATA_W  = 8;
  localparam int CORR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int OCC_W   = 5;

  logic                   clk;
  logic                   rst_n;
  logic [NCH-1:0]         sync_pulse;
  logic [NCH-1:0]         timeout_err;
  logic [NCH*OCC_W-1:0]   occupancy;
  logic [DROP_W-1:0]      drop_count;
  qci_state_t             state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  qci_handshake_mc_if #(.NCH(NCH), .DATA_W(DATA_W), .CORR_W(CORR_W)) bus ();

  qci_handshake_mc #(
    .NCH(NCH), .DATA_W(DATA_W), .CORR_W(CORR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .sync_pulse  (sync_pulse),
    .timeout_err (timeout_err),
    .occupancy   (occupancy),
    .drop_count  (drop_count),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OCC_W-1:0] occ(input int c);
    return occupancy[c*OCC_W +: OCC_W];
  endfunction

  // driver tasks
  task automatic drive(input logic cv, input logic [1:0] ch, input logic [7:0] d, input logic qr);
    bus.c_valid = cv;
    bus.c_ch    = ch;
    bus.c_data  = d;
    bus.q_ready = qr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_q_valid", bus.q_valid, 0);
    check("rst_q_corr", bus.q_corr, 0);
    check("rst_q_ch", bus.q_ch, 0);
    check("rst_sync", sync_pulse, 0);
    check("rst_tout", timeout_err, 0);
    check("rst_occ", occupancy, 0);
    check("rst_drops", drop_count, 0);
    check("rst_state", state_dbg, QCI_IDLE);
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(output logic [1:0] ch, output logic [3:0] corr, output logic ok);
    ok = 1'b0; ch = '0; corr = '0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      bus.c_valid = 1'b0;
      bus.q_ready = 1'b1;
      if (bus.q_valid) begin
        ch = bus.q_ch; corr = bus.q_corr; ok = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic       c_valid;
    logic [1:0] c_ch;
    logic [7:0] c_data;
    logic       q_ready;
    logic       exp_c_ready;
    logic       exp_q_valid;
    logic [1:0] exp_q_ch;
    logic [3:0] exp_q_corr;
    logic [3:0] exp_sync;
  } vec_t;

  vec_t vecs[14];

  // scoreboard model: one queue of expected payloads per channel
  logic [DATA_W-1:0] exp_q[NCH][$];

  task automatic run_random(input int ncyc);
    int pct_tab[4] = '{90, 50, 10, 0};
    int m_rr = 0, off_ch = 0, wait_n = 0, m_drops = 0, last_push = -1, idle_run = 0;
    int pick, ch;
    logic offering = 1'b0, in_apply = 1'b0, found, hs, drop, push, any_ne, cv, qr;
    logic [3:0] off_corr = '0, exp_sync = '0, exp_tout = '0;
    logic [7:0] d, hd;
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) check($sformatf("rnd_occ%0d", c), occ(c), exp_q[c].size());
      check("rnd_sync", sync_pulse, exp_sync);
      check("rnd_tout", timeout_err, exp_tout);
      check("rnd_drops", drop_count, m_drops);
      if (in_apply) begin
        check("rnd_apply_qvalid", bus.q_valid, 0);
        in_apply = 1'b0;
        idle_run = 0;
      end else if (offering) begin
        check("rnd_hold_qvalid", bus.q_valid, 1);
        check("rnd_hold_qch", bus.q_ch, off_ch);
        check("rnd_hold_qcorr", bus.q_corr, off_corr);
      end else if (bus.q_valid) begin
        found = 1'b0; pick = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
          int c2;
          c2 = (m_rr + k) % NCH;
          if (exp_q[c2].size() - ((last_push == c2) ? 1 : 0) > 0) begin
            found = 1'b1; pick = c2;
          end
        end
        check("rnd_grant_legal", found, 1);
        if (found) begin
          hd = exp_q[pick][0];
          check("rnd_grant_ch", bus.q_ch, pick);
          check("rnd_grant_corr", bus.q_corr, hd[3:0]);
          off_corr = hd[3:0];
        end
        offering = found; off_ch = pick; wait_n = 0; idle_run = 0;
      end else begin
        any_ne = 1'b0;
        for (int c = 0; c < NCH; c++) if (exp_q[c].size() > 0) any_ne = 1'b1;
        if (any_ne) begin
          idle_run++;
          check("rnd_idle_bound", idle_run <= 1, 1);
        end else idle_run = 0;
      end
      qr = ($urandom_range(99) < pct_tab[(cyc / 200) % 4]);
      cv = ($urandom_range(99) < 40);
      ch = $urandom_range(NCH - 1);
      d  = 8'($urandom_range(255));
      drive(cv, 2'(ch), d, qr);
      #1;
      check("rnd_c_ready", bus.c_ready, exp_q[ch].size() < DEPTH);
      push = cv && (exp_q[ch].size() < DEPTH);
      hs   = offering && qr;
      drop = offering && !qr && (wait_n == TIMEOUT - 1);
      exp_sync = '0; exp_tout = '0;
      if (hs || drop) begin
        void'(exp_q[off_ch].pop_front());
        if (hs) exp_sync[off_ch] = 1'b1;
        else begin
          exp_tout[off_ch] = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
        offering = 1'b0; in_apply = 1'b1;
        m_rr = (off_ch + 1) % NCH;
      end else if (offering) wait_n++;
      if (push) begin
        exp_q[ch].push_back(d);
        last_push = ch;
      end else last_push = -1;
    end
  endtask

  initial begin
    logic [1:0] got_ch;
    logic [3:0] got_corr;
    logic       ok;
    int         n;
    logic [1:0] exp_ch_seq[6];
    logic [3:0] exp_corr_seq[6];

    //            cv    ch    data   qr    cr    qv    qch   corr  sync
    vecs[0]  = '{1'b1, 2'd2, 8'hA5, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 4'b0000};
    vecs[1]  = '{1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 4'h5, 4'b0000};
    vecs[2]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd2, 4'h5, 4'b0100};
    vecs[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd2, 4'h5, 4'b0000};
    vecs[4]  = '{1'b1, 2'd1, 8'h3C, 1'b0, 1'b1, 1'b0, 2'd2, 4'h5, 4'b0000};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd1, 4'hC, 4'b0000};
    vecs[6]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd1, 4'hC, 4'b0000};
    vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd1, 4'hC, 4'b0010};
    vecs[8]  = '{1'b1, 2'd3, 8'h7E, 1'b1, 1'b1, 1'b0, 2'd1, 4'hC, 4'b0000};
    vecs[9]  = '{1'b1, 2'd0, 8'h91, 1'b1, 1'b1, 1'b1, 2'd3, 4'hE, 4'b0000};
    vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd3, 4'hE, 4'b1000};
    vecs[11] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd3, 4'hE, 4'b0000};
    vecs[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1, 4'b0000};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1, 4'b0001};

    // basic latency / single transfers from the vector table
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].c_valid, vecs[i].c_ch, vecs[i].c_data, vecs[i].q_ready);
      #1;
      check($sformatf("v%0d_c_ready", i), bus.c_ready, vecs[i].exp_c_ready);
      @(negedge clk);
      check($sformatf("v%0d_q_valid", i), bus.q_valid, vecs[i].exp_q_valid);
      check($sformatf("v%0d_q_ch", i), bus.q_ch, vecs[i].exp_q_ch);
      check($sformatf("v%0d_q_corr", i), bus.q_corr, vecs[i].exp_q_corr);
      check($sformatf("v%0d_sync", i), sync_pulse, vecs[i].exp_sync);
    end

    // fill ch0, full-FIFO push blocking, pop on full, push+pop same cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 2'd0, 8'(8'h30 + i), 1'b0);
      @(negedge clk);
    end
    check("full_occ0", occ(0), DEPTH);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    #1 check("full_c_ready_ch0", bus.c_ready, 0);
    drive(1'b0, 2'd1, 8'h00, 1'b0);
    #1 check("full_c_ready_ch1", bus.c_ready, 1);
    drive(1'b1, 2'd0, 8'hFF, 1'b0);
    @(negedge clk);
    check("full_blocked_occ0", occ(0), DEPTH);
    drive(1'b1, 2'd0, 8'h55, 1'b1);
    #1 check("full_pop_c_ready", bus.c_ready, 0);
    @(negedge clk);
    check("full_pop_occ0", occ(0), DEPTH - 1);
    check("full_pop_sync", sync_pulse, 4'b0001);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pp_q_valid", bus.q_valid, 1);
    check("pp_q_corr", bus.q_corr, 4'h1);
    drive(1'b1, 2'd0, 8'h66, 1'b1);
    #1 check("pp_c_ready", bus.c_ready, 1);
    @(negedge clk);
    check("pp_occ0", occ(0), DEPTH - 1);
    check("pp_sync", sync_pulse, 4'b0001);
    drive(1'b0, 2'd0, 8'h00, 1'b0);

    // round-robin order, then rotation after serving ch3
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      drive(1'b1, 2'(c), 8'(8'hA0 + c), 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    exp_ch_seq   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    exp_corr_seq = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hC, 4'hB};
    for (int k = 0; k < 3; k++) begin
      wait_hs(got_ch, got_corr, ok);
      check($sformatf("rr_hs%0d_seen", k), ok, 1);
      check($sformatf("rr_hs%0d_ch", k), got_ch, exp_ch_seq[k]);
      check($sformatf("rr_hs%0d_corr", k), got_corr, exp_corr_seq[k]);
    end
    @(negedge clk);
    drive(1'b1, 2'd3, 8'h4B, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'd0, 8'h2C, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    for (int k = 3; k < 6; k++) begin
      wait_hs(got_ch, got_corr, ok);
      check($sformatf("rr_hs%0d_seen", k), ok, 1);
      check($sformatf("rr_hs%0d_ch", k), got_ch, exp_ch_seq[k]);
      check($sformatf("rr_hs%0d_corr", k), got_corr, exp_corr_seq[k]);
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 1'b0);

    // timeout drop on ch1
    do_reset();
    drive(1'b1, 2'd1, 8'h3F, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    n = 0; ok = 1'b0;
    for (int k = 0; k < TIMEOUT + 10 && !ok; k++) begin
      @(negedge clk);
      if (bus.q_valid) n++;
      else if (n > 0) ok = 1'b1;
    end
    check("to_ended", ok, 1);
    check("to_wait_cycles", n, TIMEOUT);
    check("to_tout", timeout_err, 4'b0010);
    check("to_sync", sync_pulse, 4'b0000);
    check("to_drops", drop_count, 1);
    check("to_occ1", occ(1), 0);
    @(negedge clk);
    check("to_tout_clear", timeout_err, 4'b0000);

    // accept on the expiry cycle wins over the drop
    drive(1'b1, 2'd1, 8'h2D, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    n = 0; ok = 1'b0;
    for (int k = 0; k < TIMEOUT + 10 && !ok; k++) begin
      if (bus.q_valid) begin
        n++;
        if (n == TIMEOUT) begin
          bus.q_ready = 1'b1;
          ok = 1'b1;
        end
      end
      if (!ok) @(negedge clk);
    end
    check("exp_reached", ok, 1);
    @(negedge clk);
    bus.q_ready = 1'b0;
    check("exp_sync", sync_pulse, 4'b0010);
    check("exp_tout", timeout_err, 4'b0000);
    check("exp_drops", drop_count, 1);
    check("exp_occ1", occ(1), 0);

    // asynchronous reset while waiting with three entries queued
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 2'(c), 8'(8'h70 + c), 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    check("ar_pre_state", state_dbg, QCI_WAIT_EPR);
    check("ar_pre_qvalid", bus.q_valid, 1);
    check("ar_pre_occ", occupancy, 20'h00421);
    #2 rst_n = 1'b0;
    #1;
    check("ar_qvalid", bus.q_valid, 0);
    check("ar_occ", occupancy, 0);
    check("ar_state", state_dbg, QCI_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_after_qvalid", bus.q_valid, 0);
    check("ar_after_occ", occupancy, 0);

    // randomized traffic against the queue model
    do_reset();
    run_random(3000);

    drive(1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
